// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with a busy-bit scoreboard.
// Combinational reads with optional write bypass, registered writes.
module regfile_mp_sb #(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter int NRD    = 4,
    parameter int NWR    = 2,
    parameter int SP_IDX = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [XLEN-1:0]     initial_sp,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic [NREGS-1:0]    busy_vec,
    output logic [AW:0]         busy_cnt
);

    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [XLEN-1:0]  wr_val [NREGS];
    logic [NREGS-1:0] wr_hit;
    logic [NREGS-1:0] rsv_hit;
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;
    logic [AW:0]      n_set;
    logic [AW:0]      n_clr;

    // Per-register write/reserve decode; later ports overwrite earlier ones
    always_comb begin
        wr_hit  = '0;
        rsv_hit = '0;
        for (int r = 0; r < NREGS; r++) begin
            wr_val[r] = '0;
        end
        for (int r = 1; r < NREGS; r++) begin
            rsv_hit[r] = rsv_en && (rsv_addr == AW'(r));
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r))) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Next register contents, busy bits and incremental busy count
    always_comb begin
        n_set = '0;
        n_clr = '0;
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = wr_hit[r] ? wr_val[r] : regs_q[r];
            busy_d[r] = rsv_hit[r] | (busy_q[r] & ~wr_hit[r]);
            if (!busy_q[r] && busy_d[r]) begin
                n_set = n_set + ONE;
            end
            if (busy_q[r] && !busy_d[r]) begin
                n_clr = n_clr + ONE;
            end
        end
        cnt_d = cnt_q + n_set - n_clr;
    end

    // State registers; reset seeds the stack pointer register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= (r == SP_IDX) ? initial_sp : '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Read ports: x0 is zero, optional bypass of same-cycle writes
    always_comb begin
        logic [AW-1:0] ra;
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = rd_addr[i*AW +: AW];
            if (ra != '0) begin
                rd_data[i*XLEN +: XLEN] = regs_q[ra];
                rd_busy[i] = busy_q[ra];
                if ((BYPASS != 0) && wr_hit[ra]) begin
                    rd_data[i*XLEN +: XLEN] = wr_val[ra];
                    rd_busy[i] = rsv_hit[ra];
                end
            end
        end
    end

    assign busy_vec = busy_q;
    assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: bypass and non-bypass builds share stimulus.
// Expected values are queued at drive time and popped at sample time.
module tb_regfile_mp_sb;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 4;
    localparam int NWR   = 2;
    localparam int AW    = 5;
    localparam logic [63:0] SP = 64'h8000_0000;

    logic                clk = 1'b0;
    logic                reset;
    logic [XLEN-1:0]     initial_sp;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data0, rd_data1;
    logic [NRD-1:0]      rd_busy0, rd_busy1;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic [NREGS-1:0]    busy_vec0, busy_vec1;
    logic [AW:0]         busy_cnt0, busy_cnt1;

    int checks = 0;
    int passed = 0;
    logic [63:0] exp_q[$];
    logic [63:0] e;

    regfile_mp_sb #(.BYPASS(1)) u0 (
        .clk(clk), .reset(reset), .initial_sp(initial_sp),
        .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_vec(busy_vec0), .busy_cnt(busy_cnt0)
    );

    regfile_mp_sb #(.BYPASS(0)) u1 (
        .clk(clk), .reset(reset), .initial_sp(initial_sp),
        .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_vec(busy_vec1), .busy_cnt(busy_cnt1)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rdb(input int i);
        return rd_data0[i*XLEN +: XLEN];
    endfunction

    function automatic logic [63:0] rdn(input int i);
        return rd_data1[i*XLEN +: XLEN];
    endfunction

    task automatic clr_in();
        wr_en  = '0;
        rsv_en = 1'b0;
    endtask

    task automatic set_wr(input int j, input int a, input logic [63:0] d);
        wr_en[j] = 1'b1;
        wr_addr[j*AW +: AW] = AW'(a);
        wr_data[j*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input int i, input int a);
        rd_addr[i*AW +: AW] = AW'(a);
    endtask

    task automatic set_rsv(input int a);
        rsv_en = 1'b1;
        rsv_addr = AW'(a);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        initial_sp = SP;
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        rsv_addr = '0;
        clr_in();
        set_rd(0, 2);
        set_rd(1, 5);
        exp_q.push_back(SP);
        exp_q.push_back(SP);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        #2;
        e = exp_q.pop_front(); checks++;
        if (rdb(0) !== e) $display("FAIL rst_sp_b got %h exp %h", rdb(0), e);
        else passed++;
        e = exp_q.pop_front(); checks++;
        if (rdn(0) !== e) $display("FAIL rst_sp_n got %h exp %h", rdn(0), e);
        else passed++;
        e = exp_q.pop_front(); checks++;
        if (rdb(1) !== e) $display("FAIL rst_x5 got %h exp %h", rdb(1), e);
        else passed++;
        e = exp_q.pop_front(); checks++;
        if ({32'h0, busy_vec0} !== e)
            $display("FAIL rst_busy_vec got %h exp %h", busy_vec0, e);
        else passed++;
        e = exp_q.pop_front(); checks++;
        if ({58'h0, busy_cnt0} !== e)
            $display("FAIL rst_busy_cnt got %0d exp %0d", busy_cnt0, e);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_same_addr();
        step();
        clr_in();
        set_wr(0, 7, 64'hAAAA);
        set_wr(1, 7, 64'h5555);
        set_rd(0, 7);
        exp_q.push_back(64'h5555);
        exp_q.push_back(64'h0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (rdb(0) !== e) $display("FAIL same_byp got %h exp %h", rdb(0), e);
        else passed++;
        e = exp_q.pop_front(); checks++;
        if (rdn(0) !== e) $display("FAIL same_nobyp got %h exp %h", rdn(0), e);
        else passed++;
        exp_q.push_back(64'h5555);
        exp_q.push_back(64'h5555);
        exp_q.push_back(64'h0);
        step();
        clr_in();
        #1;
        e = exp_q.pop_front(); checks++;
        if (rdb(0) !== e) $display("FAIL same_store_b got %h exp %h", rdb(0), e);
        else passed++;
        e = exp_q.pop_front(); checks++;
        if (rdn(0) !== e) $display("FAIL same_store_n got %h exp %h", rdn(0), e);
        else passed++;
        e = exp_q.pop_front(); checks++;
        if ({32'h0, busy_vec0} !== e)
            $display("FAIL same_notbusy got %h exp %h", busy_vec0, e);
        else passed++;
    endtask

    task automatic test_x0();
        clr_in();
        set_wr(0, 0, 64'hFFFF);
        set_rsv(0);
        set_rd(0, 0);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (rdb(0) !== e) $display("FAIL x0_read got %h exp %h", rdb(0), e);
        else passed++;
        e = exp_q.pop_front(); checks++;
        if ({63'h0, rd_busy0[0]} !== e)
            $display("FAIL x0_rdbusy got %b exp %h", rd_busy0[0], e);
        else passed++;
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        step();
        clr_in();
        #1;
        e = exp_q.pop_front(); checks++;
        if ({32'h0, busy_vec0} !== e)
            $display("FAIL x0_busy got %h exp %h", busy_vec0, e);
        else passed++;
        e = exp_q.pop_front(); checks++;
        if ({58'h0, busy_cnt0} !== e)
            $display("FAIL x0_cnt got %0d exp %0d", busy_cnt0, e);
        else passed++;
    endtask

    task automatic test_scoreboard();
        clr_in();
        set_rsv(3);
        step();
        set_rsv(4);
        step();
        clr_in();
        set_rd(0, 3);
        exp_q.push_back(64'd2);
        exp_q.push_back(64'd1);
        exp_q.push_back(64'h18);
        #1;
        e = exp_q.pop_front(); checks++;
        if ({58'h0, busy_cnt0} !== e)
            $display("FAIL sb_cnt2 got %0d exp %0d", busy_cnt0, e);
        else passed++;
        e = exp_q.pop_front(); checks++;
        if ({63'h0, rd_busy0[0]} !== e)
            $display("FAIL sb_rdbusy3 got %b exp %h", rd_busy0[0], e);
        else passed++;
        e = exp_q.pop_front(); checks++;
        if ({32'h0, busy_vec0} !== e)
            $display("FAIL sb_vec got %h exp %h", busy_vec0, e);
        else passed++;
        set_wr(0, 3, 64'h33);
        set_rsv(3);
        exp_q.push_back(64'd1);
        #1;
        e = exp_q.pop_front(); checks++;
        if ({63'h0, rd_busy0[0]} !== e)
            $display("FAIL sb_wr_rsv_byp got %b exp %h", rd_busy0[0], e);
        else passed++;
        exp_q.push_back(64'd1);
        exp_q.push_back(64'd2);
        step();
        clr_in();
        #1;
        e = exp_q.pop_front(); checks++;
        if ({63'h0, busy_vec0[3]} !== e)
            $display("FAIL sb_keep3 got %b exp %h", busy_vec0[3], e);
        else passed++;
        e = exp_q.pop_front(); checks++;
        if ({58'h0, busy_cnt0} !== e)
            $display("FAIL sb_keep_cnt got %0d exp %0d", busy_cnt0, e);
        else passed++;
        set_wr(0, 3, 64'h333);
        set_wr(1, 4, 64'h444);
        set_rd(1, 4);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h3);
        #1;
        e = exp_q.pop_front(); checks++;
        if ({62'h0, rd_busy0[1:0]} !== e)
            $display("FAIL sb_byp_clr got %b exp %h", rd_busy0[1:0], e);
        else passed++;
        e = exp_q.pop_front(); checks++;
        if ({62'h0, rd_busy1[1:0]} !== e)
            $display("FAIL sb_nobyp_reg got %b exp %h", rd_busy1[1:0], e);
        else passed++;
        exp_q.push_back(64'd0);
        exp_q.push_back(64'h0);
        step();
        clr_in();
        #1;
        e = exp_q.pop_front(); checks++;
        if ({58'h0, busy_cnt0} !== e)
            $display("FAIL sb_cnt0 got %0d exp %0d", busy_cnt0, e);
        else passed++;
        e = exp_q.pop_front(); checks++;
        if ({32'h0, busy_vec0} !== e)
            $display("FAIL sb_vec0 got %h exp %h", busy_vec0, e);
        else passed++;
        set_rsv(3);
        step();
        step();
        clr_in();
        exp_q.push_back(64'd1);
        #1;
        e = exp_q.pop_front(); checks++;
        if ({58'h0, busy_cnt0} !== e)
            $display("FAIL sb_rsv_twice got %0d exp %0d", busy_cnt0, e);
        else passed++;
        set_wr(0, 3, 64'h3);
        step();
        clr_in();
        exp_q.push_back(64'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if ({58'h0, busy_cnt1} !== e)
            $display("FAIL sb_release got %0d exp %0d", busy_cnt1, e);
        else passed++;
    endtask

    task automatic test_bypass0();
        clr_in();
        set_wr(0, 9, 64'h1234);
        set_rd(1, 9);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h1234);
        #1;
        e = exp_q.pop_front(); checks++;
        if (rdn(1) !== e) $display("FAIL b0_old got %h exp %h", rdn(1), e);
        else passed++;
        e = exp_q.pop_front(); checks++;
        if (rdb(1) !== e) $display("FAIL b1_new got %h exp %h", rdb(1), e);
        else passed++;
        exp_q.push_back(64'h1234);
        step();
        clr_in();
        #1;
        e = exp_q.pop_front(); checks++;
        if (rdn(1) !== e) $display("FAIL b0_next got %h exp %h", rdn(1), e);
        else passed++;
    endtask

    task automatic test_async_reset();
        clr_in();
        set_wr(0, 5, 64'hDEAD);
        set_rsv(5);
        step();
        clr_in();
        set_rsv(6);
        step();
        set_rsv(7);
        step();
        clr_in();
        set_rd(0, 5);
        set_rd(1, 2);
        exp_q.push_back(64'd3);
        exp_q.push_back(64'hDEAD);
        #1;
        e = exp_q.pop_front(); checks++;
        if ({58'h0, busy_cnt0} !== e)
            $display("FAIL ar_pre_cnt got %0d exp %0d", busy_cnt0, e);
        else passed++;
        e = exp_q.pop_front(); checks++;
        if (rdb(0) !== e) $display("FAIL ar_pre_x5 got %h exp %h", rdb(0), e);
        else passed++;
        #1;
        reset = 1'b1;
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        exp_q.push_back(SP);
        #1;
        e = exp_q.pop_front(); checks++;
        if (rdb(0) !== e) $display("FAIL ar_x5 got %h exp %h", rdb(0), e);
        else passed++;
        e = exp_q.pop_front(); checks++;
        if ({32'h0, busy_vec0} !== e)
            $display("FAIL ar_vec got %h exp %h", busy_vec0, e);
        else passed++;
        e = exp_q.pop_front(); checks++;
        if ({58'h0, busy_cnt1} !== e)
            $display("FAIL ar_cnt got %0d exp %0d", busy_cnt1, e);
        else passed++;
        e = exp_q.pop_front(); checks++;
        if (rdn(1) !== e) $display("FAIL ar_sp got %h exp %h", rdn(1), e);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [NREGS-1:0] mb;
        int a;
        int rv;
        logic re;
        logic [63:0] d;
        mb = '0;
        step();
        for (int n = 0; n < 16; n++) begin
            a  = $urandom_range(31, 1);
            rv = $urandom_range(31, 0);
            re = 1'($urandom_range(1, 0));
            d  = {$urandom, $urandom};
            clr_in();
            set_wr(0, a, d);
            rsv_en = re;
            rsv_addr = AW'(rv);
            set_rd(2, a);
            exp_q.push_back(d);
            exp_q.push_back(d);
            mb[a] = 1'b0;
            if (re && rv != 0) mb[rv] = 1'b1;
            exp_q.push_back({32'h0, mb});
            exp_q.push_back(64'($countones(mb)));
            #1;
            e = exp_q.pop_front(); checks++;
            if (rdb(2) !== e) $display("FAIL b2b_byp[%0d] got %h exp %h", n, rdb(2), e);
            else passed++;
            step();
            e = exp_q.pop_front(); checks++;
            if (rdn(2) !== e) $display("FAIL b2b_store[%0d] got %h exp %h", n, rdn(2), e);
            else passed++;
            e = exp_q.pop_front(); checks++;
            if ({32'h0, busy_vec0} !== e)
                $display("FAIL b2b_vec[%0d] got %h exp %h", n, busy_vec0, e);
            else passed++;
            e = exp_q.pop_front(); checks++;
            if ({58'h0, busy_cnt0} !== e)
                $display("FAIL b2b_cnt[%0d] got %0d exp %0d", n, busy_cnt0, e);
            else passed++;
        end
        clr_in();
    endtask

    initial begin
        test_reset();
        test_same_addr();
        test_x0();
        test_scoreboard();
        test_bypass0();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-port integer register file with an integrated busy-bit scoreboard. It is the next-generation register file for the pipelined/dual-issue core. It provides NRD combinational read ports and NWR write ports, with optional same-cycle write-to-read bypass. Per-register busy tracking lets decode detect RAW hazards on registers with in-flight producers.

Parameters:
XLEN, 64, register width in bits
NREGS, 32, number of architectural registers (power of 2, >=4)
NRD, 4, number of read ports
NWR, 2, number of write ports
SP_IDX, 2, register loaded with initial_sp on reset
BYPASS, 1, 1 = read port returns same-cycle write data; 0 = returns stored value
AW, $clog2(NREGS), derived address width (localparam)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
initial_sp  in  XLEN  value loaded into register SP_IDX on reset
rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
rd_data  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
rd_busy  out  NRD  port i address has a pending producer
wr_en  in  NWR  write enable per port
wr_addr  in  NWR*AW  write addresses
wr_data  in  NWR*XLEN  write data
rsv_en  in  1  reserve (mark busy) a destination at issue
rsv_addr  in  AW  register to reserve
busy_vec  out  NREGS  full scoreboard, bit r = register r busy
busy_cnt  out  AW+1  number of busy registers

Behaviour:
- Reset (async, any cycle, including mid-operation): all registers = 0 except reg[SP_IDX] = initial_sp. All busy bits = 0 and busy_cnt = 0. In-flight writes and reservations are discarded.
- Register 0 is hardwired zero: writes are ignored, reads return 0, reservations are ignored, and the busy bit is always 0.
- Writes are registered on posedge clk: reg[wr_addr[j]] <= wr_data[j] when wr_en[j]=1 and wr_addr[j]!=0.
- Multiple write ports targeting the same address in one cycle: the highest-index port wins, for both data and bypass.
- Reads are combinational, zero latency.
  - BYPASS=1: if any enabled write port targets rd_addr[i] (nonzero), rd_data[i] is that write's data (highest-index port wins); otherwise it is the stored value.
  - BYPASS=0: rd_data[i] is always the stored value; the new value is visible the cycle after the write.
- Scoreboard update per cycle, per register r:
  - set when rsv_en and rsv_addr==r;
  - cleared when any enabled write port targets r.
  - Reserve and write to the same r in the same cycle: busy stays 1, because the new producer supersedes the old.
  - Writing a register that is not busy is legal: data is updated and busy stays 0.
  - Reserving an already-busy register is legal: busy stays 1 with no error and no counting; it is a single bit, not a counter.
- rd_busy[i] = busy_vec[rd_addr[i]], combinational from registered state.
  - With BYPASS=1, a same-cycle write to that address forces rd_busy[i]=0 unless rsv_en also targets it in that cycle.
  - With BYPASS=0, rd_busy[i] reflects registered state only.
- busy_cnt is registered and always equals popcount(busy_vec). It is maintained incrementally: +1 on a 0->1 transition, -1 per distinct register going 1->0, with both applied in the same cycle. Range is 0..NREGS-1.
- No X propagation: every output is defined from reset onward.

Test Plan:
- Reset with initial_sp=64'h8000_0000 -> rd_addr port0=2 reads 64'h8000_0000; port1=5 reads 0; busy_vec=0; busy_cnt=0.
- Write wr_en=2'b11 with port0 (x7, 64'hAAAA) and port1 (x7, 64'h5555) in one cycle -> BYPASS=1 read of x7 returns 64'h5555 that cycle; stored x7=64'h5555 next cycle.
- Write x0=64'hFFFF together with rsv x0 -> x0 reads 0; busy_vec[0]=0; busy_cnt unchanged.
- rsv x3, then x4 on consecutive cycles -> busy_cnt=2 and rd_busy high on x3. Next cycle: write x3 and rsv x3 together -> busy_vec[3] stays 1, busy_cnt=2. Then write x3 and x4 on both ports -> busy_cnt=0.
- BYPASS=0 build: write x9=64'h1234 -> same-cycle read of x9 returns the old value 0; the next cycle returns 64'h1234.
- Assert reset mid-sequence (busy_cnt=3, x5=64'hDEAD), asynchronously between clock edges -> outputs are immediately reset values; x5 reads 0, busy_vec=0.
